// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register. It captures the register-file operands,
// the immediate, the register indices and the control word of the instruction
// leaving decode. Before each operand is registered it is resolved against the
// in-flight writebacks, so execute never sees stale register-file data.
//
// Operand resolution (rn -> op1, rm -> op2):
//   index 31 (XZR)               -> 0, and XZR is never forwarded
//   EX/MEM writes this index     -> exm_result
//   MEM/WB writes this index     -> wb_data
//   otherwise                    -> register-file read data
//
// Edge priority: reset > flush > stall > normal load.
//   flush : every output is cleared to a bubble, and bubble_count increments.
//   stall : every output holds its value, and bubble_count increments.
//
// Ports
//   clk, reset             rising-edge clock and synchronous active-high reset
//   stall, flush           hold the current contents / insert a bubble
//   in_valid, in_rn/rm/rd  decode slot valid flag and register indices
//   read_data1/2           register-file read data, aligned with in_rn/in_rm
//   in_imm, in_ctrl        sign-extended immediate and opaque control bundle
//   exm_regwrite/rd/result EX/MEM forwarding source
//   wb_regwrite/rd/data    MEM/WB forwarding source
//   out_*                  registered execute-slot contents
//   bubble_count           saturating count of stalled or flushed cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int WORD   = 64,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [4:0]        in_rd,
    input  logic [WORD-1:0]   read_data1,
    input  logic [WORD-1:0]   read_data2,
    input  logic [WORD-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              exm_regwrite,
    input  logic [4:0]        exm_rd,
    input  logic [WORD-1:0]   exm_result,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [WORD-1:0]   wb_data,
    output logic              out_valid,
    output logic [4:0]        out_rn,
    output logic [4:0]        out_rm,
    output logic [4:0]        out_rd,
    output logic [WORD-1:0]   out_op1,
    output logic [WORD-1:0]   out_op2,
    output logic [WORD-1:0]   out_imm,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [4:0] XZR = 5'd31;

    logic              valid_q;
    logic [4:0]        rn_q, rm_q, rd_q;
    logic [WORD-1:0]   op1_q, op2_q, imm_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  bubble_q;

    logic [WORD-1:0]   op1_d, op2_d;

    // XZR is tested first so that a writeback that names register 31 cannot
    // leak a value into a zero-register read.
    function automatic logic [WORD-1:0] resolve(
        input logic [4:0]      idx,
        input logic [WORD-1:0] rf_data,
        input logic            exm_we,
        input logic [4:0]      exm_idx,
        input logic [WORD-1:0] exm_val,
        input logic            wb_we,
        input logic [4:0]      wb_idx,
        input logic [WORD-1:0] wb_val
    );
        logic [WORD-1:0] r;
        if (idx == XZR)
            r = '0;
        else if (exm_we && (exm_idx == idx))
            r = exm_val;
        else if (wb_we && (wb_idx == idx))
            r = wb_val;
        else
            r = rf_data;
        return r;
    endfunction

    always_comb begin
        op1_d = resolve(in_rn, read_data1, exm_regwrite, exm_rd, exm_result,
                        wb_regwrite, wb_rd, wb_data);
        op2_d = resolve(in_rm, read_data2, exm_regwrite, exm_rd, exm_result,
                        wb_regwrite, wb_rd, wb_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            imm_q    <= '0;
            ctrl_q   <= '0;
            bubble_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
                rn_q    <= '0;
                rm_q    <= '0;
                rd_q    <= '0;
                op1_q   <= '0;
                op2_q   <= '0;
                imm_q   <= '0;
                ctrl_q  <= '0;
            end else if (!stall) begin
                valid_q <= in_valid;
                rn_q    <= in_rn;
                rm_q    <= in_rm;
                rd_q    <= in_rd;
                op1_q   <= op1_d;
                op2_q   <= op2_d;
                imm_q   <= in_imm;
                ctrl_q  <= in_ctrl;
            end
            // Saturate rather than wrap, so a long debug run never reads low.
            if ((flush || stall) && (bubble_q != {CNT_W{1'b1}}))
                bubble_q <= bubble_q + 1'b1;
        end
    end

    assign out_valid    = valid_q;
    assign out_rn       = rn_q;
    assign out_rm       = rm_q;
    assign out_rd       = rd_q;
    assign out_op1      = op1_q;
    assign out_op2      = op2_q;
    assign out_imm      = imm_q;
    assign out_ctrl     = ctrl_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. The counter is built narrow (CNT_W=4) so
// that saturation is reached by real stall cycles instead of a forced value.
module tb_id_ex_stage;

    localparam int WORD   = 64;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset, stall, flush, in_valid;
    logic [4:0]        in_rn, in_rm, in_rd;
    logic [WORD-1:0]   read_data1, read_data2, in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic              exm_regwrite, wb_regwrite;
    logic [4:0]        exm_rd, wb_rd;
    logic [WORD-1:0]   exm_result, wb_data;
    logic              out_valid;
    logic [4:0]        out_rn, out_rm, out_rd;
    logic [WORD-1:0]   out_op1, out_op2, out_imm;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  bubble_count;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WORD(WORD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
        .read_data1(read_data1), .read_data2(read_data2),
        .in_imm(in_imm), .in_ctrl(in_ctrl),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_rn(out_rn), .out_rm(out_rm), .out_rd(out_rd),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_ctrl(out_ctrl), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " valid"}, 64'(out_valid), 64'd0);
        chk({tag, " rn"},    64'(out_rn),    64'd0);
        chk({tag, " rm"},    64'(out_rm),    64'd0);
        chk({tag, " rd"},    64'(out_rd),    64'd0);
        chk({tag, " op1"},   out_op1,        64'd0);
        chk({tag, " op2"},   out_op2,        64'd0);
        chk({tag, " imm"},   out_imm,        64'd0);
        chk({tag, " ctrl"},  64'(out_ctrl),  64'd0);
    endtask

    initial begin
        // Reset with nonzero inputs everywhere.
        reset = 1; stall = 0; flush = 0; in_valid = 1;
        in_rn = 5'd3; in_rm = 5'd4; in_rd = 5'd7;
        read_data1 = 64'h11; read_data2 = 64'h22;
        in_imm = 64'h55; in_ctrl = 16'h1234;
        exm_regwrite = 1; exm_rd = 5'd9;  exm_result = 64'h99;
        wb_regwrite  = 1; wb_rd  = 5'd10; wb_data    = 64'hA0;
        step(); step();
        check_all_zero("reset");
        chk("reset bubble", 64'(bubble_count), 64'd0);

        // Plain load, forwarding sources name other registers.
        reset = 0;
        step();
        chk("load valid", 64'(out_valid), 64'd1);
        chk("load op1",   out_op1, 64'h11);
        chk("load op2",   out_op2, 64'h22);
        chk("load rn",    64'(out_rn), 64'd3);
        chk("load rm",    64'(out_rm), 64'd4);
        chk("load rd",    64'(out_rd), 64'd7);
        chk("load imm",   out_imm, 64'h55);
        chk("load ctrl",  64'(out_ctrl), 64'h1234);
        chk("load bubble", 64'(bubble_count), 64'd0);

        // Both forwarding stages match rn: EX/MEM must win. rm only MEM/WB-free.
        in_rn = 5'd5; read_data1 = 64'h50;
        in_rm = 5'd6; read_data2 = 64'h66;
        exm_regwrite = 1; exm_rd = 5'd5; exm_result = 64'hAA;
        wb_regwrite  = 1; wb_rd  = 5'd5; wb_data    = 64'hBB;
        step();
        chk("fwd exm op1", out_op1, 64'hAA);
        chk("fwd none op2", out_op2, 64'h66);

        // Drop EX/MEM: MEM/WB now supplies op1; rm also hits MEM/WB.
        exm_regwrite = 0; in_rm = 5'd5; read_data2 = 64'h77;
        step();
        chk("fwd wb op1", out_op1, 64'hBB);
        chk("fwd wb op2", out_op2, 64'hBB);

        // EX/MEM forwards to op2 only.
        exm_regwrite = 1; exm_rd = 5'd6; exm_result = 64'hCC;
        in_rn = 5'd8; read_data1 = 64'h88; in_rm = 5'd6;
        step();
        chk("fwd exm op2", out_op2, 64'hCC);
        chk("fwd none op1", out_op1, 64'h88);

        // XZR on both operands with writebacks aimed at register 31.
        in_rn = 5'd31; read_data1 = 64'hFF; in_rm = 5'd31; read_data2 = 64'hEE;
        exm_regwrite = 1; exm_rd = 5'd31; exm_result = 64'h1;
        wb_regwrite  = 1; wb_rd  = 5'd31; wb_data    = 64'h2;
        step();
        chk("xzr op1", out_op1, 64'd0);
        chk("xzr op2", out_op2, 64'd0);

        // in_valid=0 still registers the fields.
        in_valid = 0; in_rd = 5'd12; in_rn = 5'd1; read_data1 = 64'h1234;
        exm_regwrite = 0; wb_regwrite = 0;
        step();
        chk("dead valid", 64'(out_valid), 64'd0);
        chk("dead rd",    64'(out_rd), 64'd12);
        chk("dead op1",   out_op1, 64'h1234);

        // Load a known instruction, then stall 3 cycles with changing inputs.
        in_valid = 1; in_rn = 5'd3; read_data1 = 64'h11;
        in_rm = 5'd4; read_data2 = 64'h22; in_rd = 5'd7;
        in_imm = 64'h55; in_ctrl = 16'h1234;
        step();
        chk("pre-stall op2", out_op2, 64'h22);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_rn = 5'(i + 13); read_data1 = 64'(i + 64'h300);
            read_data2 = 64'(i + 64'h400); in_imm = 64'(i);
            in_ctrl = 16'(i + 16'h700); in_valid = i[0];
            step();
        end
        chk("stall valid", 64'(out_valid), 64'd1);
        chk("stall op1",   out_op1, 64'h11);
        chk("stall op2",   out_op2, 64'h22);
        chk("stall rn",    64'(out_rn), 64'd3);
        chk("stall imm",   out_imm, 64'h55);
        chk("stall ctrl",  64'(out_ctrl), 64'h1234);
        chk("stall bubble", 64'(bubble_count), 64'd3);

        // Flush wins over a simultaneous stall.
        flush = 1;
        step();
        check_all_zero("flush");
        chk("flush bubble", 64'(bubble_count), 64'd4);

        // Stall up to saturation (15), then one more edge must not wrap.
        flush = 0;
        for (int i = 0; i < 11; i++) step();
        chk("sat reach", 64'(bubble_count), 64'd15);
        step();
        chk("sat hold stall", 64'(bubble_count), 64'd15);
        stall = 0; flush = 1;
        step();
        chk("sat hold flush", 64'(bubble_count), 64'd15);

        // Normal load after saturation does not count.
        flush = 0; in_valid = 1; in_rn = 5'd2; read_data1 = 64'h2222;
        step();
        chk("post op1", out_op1, 64'h2222);
        chk("post bubble", 64'(bubble_count), 64'd15);

        // Mid-operation reset discards the held instruction and clears the count.
        reset = 1; stall = 1;
        step();
        check_all_zero("midreset");
        chk("midreset bubble", 64'(bubble_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
